// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Sequences the reset of an Altera PLL and qualifies its locked output before
// releasing the reset of the PLL output domain. The block runs on the PLL
// reference clock. Each attempt holds the PLL in reset, then waits a bounded
// time for lock. A timeout causes a retry. Lock must then stay high for a
// number of consecutive cycles before the downstream domain is released.
// If lock is lost while running, the whole sequence starts again.
//
// Optional feature macro: PLL_SEQ_STATUS_EN
//   When defined, adds lock_loss_count and state_out status outputs.
//
// Ports:
//   clk             in   reference clock (same net as the PLL refclk)
//   reset_n         in   asynchronous active-low reset
//   pll_locked      in   PLL locked output, asynchronous to clk
//   sw_restart      in   single-cycle request to restart the sequence
//   pll_rst         out  PLL rst pin, active-high
//   sys_reset_n     out  active-low reset for the PLL output domain
//   ready           out  high while running with a qualified lock
//   fail            out  high after MAX_RETRIES lock timeouts
//   retry_count     out  lock timeouts in the current sequence
//   lock_loss_count out  (PLL_SEQ_STATUS_EN) saturating count of lock losses
//   state_out       out  (PLL_SEQ_STATUS_EN) current state encoding
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 5000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       sw_restart,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_count
`ifdef PLL_SEQ_STATUS_EN
    ,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state_out
`endif
);

    // Shared counter must cover the largest of the three phase lengths.
    localparam int unsigned CntMaxAB = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT
                                                                      : STABLE_CYCLES;
    localparam int unsigned CntMax   = (CntMaxAB > RST_CYCLES) ? CntMaxAB : RST_CYCLES;
    localparam int unsigned CntW     = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne      = CntW'(1);
    localparam logic [3:0]      MaxRetries  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetPll = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFail     = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      retry_q, retry_d;
    logic            lock_meta_q, lock_s_q;
    logic            pll_rst_q, sys_reset_n_q, ready_q, fail_q;

    // Two-flop synchronizer for the asynchronous PLL lock signal.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state logic. sw_restart overrides every lock or timer event.
    // The shared counter clears on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (sw_restart) begin
            state_d = StResetPll;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StResetPll: begin
                    if (cnt_q == RstLast) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StWaitLock: begin
                    if (lock_s_q) begin
                        state_d = StStable;
                        cnt_d   = '0;
                    end else if (cnt_q == TimeoutLast) begin
                        retry_d = retry_q + 4'd1;
                        cnt_d   = '0;
                        state_d = (retry_d == MaxRetries) ? StFail : StResetPll;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StStable: begin
                    if (!lock_s_q) begin
                        // Chatter: restart the wait without counting a timeout.
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else if (cnt_q == StableLast) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StRun: begin
                    // No filtering here: any captured low sample drops the domain.
                    if (!lock_s_q) begin
                        state_d = StResetPll;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                StFail: begin
                    // Held until sw_restart or reset_n.
                end
                default: begin
                    state_d = StResetPll;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // State register with outputs decoded from the next state, so each output
    // changes on the same edge that enters its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StResetPll;
            cnt_q         <= '0;
            retry_q       <= '0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pll_rst_q     <= (state_d == StResetPll) || (state_d == StFail);
            sys_reset_n_q <= (state_d == StRun);
            ready_q       <= (state_d == StRun);
            fail_q        <= (state_d == StFail);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset_n = sys_reset_n_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

`ifdef PLL_SEQ_STATUS_EN
    logic [7:0] lock_loss_q;
    logic       lock_loss_evt;

    // A restart in the same cycle as a low lock sample is a restart, not a loss.
    assign lock_loss_evt = (state_q == StRun) && !lock_s_q && !sw_restart;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_loss_q <= 8'd0;
        end else if (lock_loss_evt && (lock_loss_q != 8'hff)) begin
            lock_loss_q <= lock_loss_q + 8'd1;
        end
    end

    assign lock_loss_count = lock_loss_q;
    assign state_out       = state_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Directed bench for pll_lock_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8 and MAX_RETRIES=3. Inputs are driven 1 time unit after a
// rising edge and outputs are sampled at the same point. Every expected value
// is hand-computed from the edge count since the last event.
// Optional status checks are compiled when PLL_SEQ_STATUS_EN is defined.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    logic       clk;
    logic       reset_n;
    logic       pll_locked;
    logic       sw_restart;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;
`ifdef PLL_SEQ_STATUS_EN
    logic [7:0] lock_loss_count;
    logic [2:0] state_out;
`endif

    int vectors;
    int miscompares;

    pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .sw_restart (sw_restart),
        .pll_rst    (pll_rst),
        .sys_reset_n(sys_reset_n),
        .ready      (ready),
        .fail       (fail),
        .retry_count(retry_count)
`ifdef PLL_SEQ_STATUS_EN
        ,
        .lock_loss_count(lock_loss_count),
        .state_out      (state_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        pll_locked  = 1'b0;
        sw_restart  = 1'b0;

        // Reset values
        tick(3);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_sys_reset_n", sys_reset_n, 0);
        check("rst_ready", ready, 0);
        check("rst_fail", fail, 0);
        check("rst_retry", retry_count, 0);

        // Nominal lock: pll_rst high for exactly 4 edges after release
        reset_n = 1'b1;
        tick(3);
        check("nom_rst_held", pll_rst, 1);
        tick(1);
        check("nom_rst_fall", pll_rst, 0);
        // Lock rises 10 cycles after pll_rst falls: lock_s 2 edges later,
        // STABLE on the following edge, RUN 8 edges after that.
        tick(9);
        pll_locked = 1'b1;
        tick(10);
        check("nom_ready_early", ready, 0);
        check("nom_sysrst_early", sys_reset_n, 0);
        tick(1);
        check("nom_ready", ready, 1);
        check("nom_sysrst", sys_reset_n, 1);
        check("nom_retry", retry_count, 0);

        // Loss in RUN: outputs drop three edges after the drop
        pll_locked = 1'b0;
        tick(2);
        check("loss_ready_hold", ready, 1);
        tick(1);
        check("loss_ready", ready, 0);
        check("loss_sysrst", sys_reset_n, 0);
        check("loss_pll_rst", pll_rst, 1);
        check("loss_retry", retry_count, 0);
`ifdef PLL_SEQ_STATUS_EN
        check("loss_count1", lock_loss_count, 1);
`endif
        tick(3);
        check("loss_rst_held", pll_rst, 1);
        tick(1);
        check("loss_rst_fall", pll_rst, 0);

        // Relock with 2-cycle chatter during STABLE
        pll_locked = 1'b1;
        tick(4);
        pll_locked = 1'b0;
        tick(2);
        pll_locked = 1'b1;
        tick(5);
        check("chat_no_early_run", ready, 0);
        tick(5);
        check("chat_ready_early", ready, 0);
        tick(1);
        check("chat_ready", ready, 1);
        check("chat_retry", retry_count, 0);

        // Timeout to FAIL: drop lock from RUN, then never relock
        pll_locked = 1'b0;
        tick(3);
        check("to_enter_reset", ready, 0);
`ifdef PLL_SEQ_STATUS_EN
        check("to_loss_count2", lock_loss_count, 2);
`endif
        tick(35);
        check("to1_retry_before", retry_count, 0);
        check("to1_pll_rst_low", pll_rst, 0);
        tick(1);
        check("to1_retry", retry_count, 1);
        check("to1_pll_rst", pll_rst, 1);
        tick(35);
        check("to2_retry_before", retry_count, 1);
        tick(1);
        check("to2_retry", retry_count, 2);
        tick(35);
        check("to3_fail_before", fail, 0);
        check("to3_retry_before", retry_count, 2);
        tick(1);
        check("to3_fail", fail, 1);
        check("to3_retry", retry_count, 3);
        check("to3_pll_rst", pll_rst, 1);
        check("to3_sysrst", sys_reset_n, 0);
        tick(120);
        check("fail_hold", fail, 1);
        check("fail_hold_pll_rst", pll_rst, 1);
        check("fail_hold_sysrst", sys_reset_n, 0);
        check("fail_hold_retry", retry_count, 3);

        // sw_restart in FAIL
        sw_restart = 1'b1;
        tick(1);
        sw_restart = 1'b0;
        check("swr_fail_cleared", fail, 0);
        check("swr_retry", retry_count, 0);
        check("swr_pll_rst", pll_rst, 1);
`ifdef PLL_SEQ_STATUS_EN
        check("swr_loss_kept", lock_loss_count, 2);
        check("swr_state", state_out, 0);
`endif
        // sw_restart during RESET_PLL restarts the 4-cycle hold
        tick(2);
        sw_restart = 1'b1;
        tick(1);
        sw_restart = 1'b0;
        tick(3);
        check("swr_rst_restart_held", pll_rst, 1);
        tick(1);
        check("swr_rst_restart_fall", pll_rst, 0);

        // sw_restart colliding with STABLE completion
        pll_locked = 1'b1;
        tick(10);
        check("col_ready_before", ready, 0);
        sw_restart = 1'b1;
        tick(1);
        sw_restart = 1'b0;
        check("col_ready", ready, 0);
        check("col_sysrst", sys_reset_n, 0);
        check("col_pll_rst", pll_rst, 1);
        check("col_retry", retry_count, 0);
        tick(12);
        check("col_no_run", ready, 0);
        tick(1);
        check("col_recover_ready", ready, 1);

        // Asynchronous reset between edges while in RUN
        #2;
        reset_n = 1'b0;
        #1;
        check("async_sysrst", sys_reset_n, 0);
        check("async_pll_rst", pll_rst, 1);
        check("async_ready", ready, 0);
`ifdef PLL_SEQ_STATUS_EN
        check("async_loss_count", lock_loss_count, 0);
`endif
        tick(2);
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the reset of a general-purpose fractional-off Altera PLL (50 MHz refclk to 25 MHz outclk) and qualifies its `locked` output.
- Drives the PLL `rst` pin, waits for lock with timeout and retry, and requires lock to stay stable before releasing the downstream domain reset.
- On loss of lock it re-asserts that reset. It sits beside the PLL wrapper in the clock/reset subsystem and runs on the 50 MHz reference clock.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per attempt (must be ≥1).
- LOCK_TIMEOUT, 5000: cycles to wait for synchronized lock before retrying (≥2).
- STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before release (≥1).
- MAX_RETRIES, 3: timeouts tolerated before entering FAIL (1..15).

Ports:
- clk  in  1  50 MHz reference clock; same net as the PLL refclk.
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked output; asynchronous to clk.
- sw_restart  in  1  single-cycle request to restart the sequence.
- pll_rst  out  1  drives the PLL rst pin; active-high.
- sys_reset_n  out  1  active-low reset for the PLL output domain; the consumer synchronizes its deassertion.
- ready  out  1  high while in RUN.
- fail  out  1  high while in FAIL.
- retry_count  out  4  number of timeouts in the current sequence; saturates at MAX_RETRIES.

Behaviour:
- Reset values (reset_n low): pll_rst=1, sys_reset_n=0, ready=0, fail=0, retry_count=0, state=RESET_PLL, all counters 0, synchronizer flops 0.
- pll_locked passes through a 2-flop synchronizer; lock_s is the second flop. Latency is 2 clk cycles.
- All outputs are registered and decoded from the state in the same cycle they are entered.
- States:
  - RESET_PLL:
    - pll_rst=1, sys_reset_n=0.
    - Holds for exactly RST_CYCLES cycles, then goes to WAIT_LOCK.
  - WAIT_LOCK:
    - pll_rst=0; the timer counts from 0.
    - If lock_s=1, go to STABLE.
    - If the timer reaches LOCK_TIMEOUT-1 with lock_s=0, increment retry_count:
      - if the new value equals MAX_RETRIES, go to FAIL;
      - otherwise go to RESET_PLL.
  - STABLE:
    - Counts consecutive cycles with lock_s=1.
    - If lock_s=0, return to WAIT_LOCK with the timer cleared; retry_count is unchanged.
    - After STABLE_CYCLES consecutive high cycles, go to RUN.
  - RUN:
    - sys_reset_n=1, ready=1.
    - If lock_s=0 for one cycle, go to RESET_PLL:
      - sys_reset_n falls on the next edge;
      - retry_count clears to 0 (a loss of lock is not a timeout).
  - FAIL:
    - pll_rst=1, sys_reset_n=0, fail=1.
    - retry_count holds its value.
    - Exits only on sw_restart or reset_n.
- Priority: sw_restart in any state takes precedence over every lock or timer event in the same cycle. It moves to RESET_PLL, clears retry_count and clears all counters.
- A sw_restart during RESET_PLL restarts the RST_CYCLES count.
- Glitch tolerance: a pll_locked glitch shorter than one clk period may or may not be captured. If captured in STABLE or RUN, it must cause the transition above; there is no filtering in RUN.
- Counter width is $clog2(max(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES)+1). The WAIT_LOCK timer and the STABLE counter share one counter, which clears on every state change.
- Asserting reset_n mid-operation returns everything to the reset values immediately (asynchronous). sys_reset_n must drop with no clock.

Optional Feature:
- Macro: PLL_SEQ_STATUS_EN.
- When defined, two extra outputs are present:
  - lock_loss_count (8 bits, saturating at 255): increments on each RUN to RESET_PLL transition due to lost lock. Cleared only by reset_n; sw_restart does not clear it.
  - state_out (3 bits): encoding RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=3):
- Nominal lock:
  - Stimulus: release reset_n; PLL model raises pll_locked 10 cycles after pll_rst falls.
  - Required: pll_rst high exactly 4 cycles; lock_s 2 cycles after pll_locked rises; ready=1 and sys_reset_n=1 exactly 8 cycles after STABLE is entered.
- Lock chatter:
  - Stimulus: pll_locked drops for 2 cycles during STABLE.
  - Required: returns to WAIT_LOCK; STABLE count restarts; retry_count stays 0; ready asserts only after 8 clean cycles.
- Timeout to fail:
  - Stimulus: pll_locked held at 0.
  - Required: three RESET_PLL(4)+WAIT_LOCK(32) cycles with retry_count 1, 2, then 3 and FAIL; fail=1, pll_rst=1, sys_reset_n=0 held for more than 100 cycles.
- Loss in RUN:
  - Stimulus: in RUN, drop pll_locked.
  - Required: sys_reset_n=0 and ready=0 three edges after the drop; pll_rst=1 for 4 cycles; relock reaches RUN again; lock_loss_count=1 with PLL_SEQ_STATUS_EN.
- sw_restart precedence:
  - Stimulus: pulse sw_restart in FAIL; separately, pulse it in the same cycle as STABLE completion.
  - Required: both go to RESET_PLL with retry_count=0; RUN is never entered in the collision case.
- Asynchronous reset:
  - Stimulus: assert reset_n between clock edges while in RUN.
  - Required: sys_reset_n=0 and pll_rst=1 before the next clk edge.
